seg7_scan_driver: RTL

// Multiplexed N-digit hex 7-segment display driver for the lab boards.

---
 rtl/seg7_pkg.sv | 27 ++
 rtl/seg7_glyph.sv | 30 +++
 rtl/seg7_scan_driver.sv | 89 ++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: active-high 7-segment glyph constants and a width helper
package seg7_pkg;
  localparam logic [6:0] SEG7_0 = 7'h3F;
  localparam logic [6:0] SEG7_1 = 7'h06;
  localparam logic [6:0] SEG7_2 = 7'h5B;
  localparam logic [6:0] SEG7_3 = 7'h4F;
  localparam logic [6:0] SEG7_4 = 7'h66;
  localparam logic [6:0] SEG7_5 = 7'h6D;
  localparam logic [6:0] SEG7_6 = 7'h7D;
  localparam logic [6:0] SEG7_7 = 7'h07;
  localparam logic [6:0] SEG7_8 = 7'h7F;
  localparam logic [6:0] SEG7_9 = 7'h6F;
  localparam logic [6:0] SEG7_A = 7'h77;
  localparam logic [6:0] SEG7_B = 7'h7C;
  localparam logic [6:0] SEG7_C = 7'h39;
  localparam logic [6:0] SEG7_D = 7'h5E;
  localparam logic [6:0] SEG7_E = 7'h79;
  localparam logic [6:0] SEG7_F = 7'h71;
  localparam logic [6:0] SEG7_OFF = 7'h00;
  // Never returns less than 1 so that counters for a range of 1 still get a bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/seg7_glyph.sv
// seg7_glyph: hex nibble to active-high 7-segment glyph (bit0=a .. bit6=g)
//   nib   in  4  hex digit
//   glyph out 7  segment pattern, 1 = lit
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] glyph
);
  always_comb begin
    case (nib)
      4'h0: glyph = SEG7_0;
      4'h1: glyph = SEG7_1;
      4'h2: glyph = SEG7_2;
      4'h3: glyph = SEG7_3;
      4'h4: glyph = SEG7_4;
      4'h5: glyph = SEG7_5;
      4'h6: glyph = SEG7_6;
      4'h7: glyph = SEG7_7;
      4'h8: glyph = SEG7_8;
      4'h9: glyph = SEG7_9;
      4'hA: glyph = SEG7_A;
      4'hB: glyph = SEG7_B;
      4'hC: glyph = SEG7_C;
      4'hD: glyph = SEG7_D;
      4'hE: glyph = SEG7_E;
      default: glyph = SEG7_F;
    endcase
  end
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed N-digit hex 7-segment scanner with blanking, blink, dp and ghost guard
//   clk, rst_n              clock, async active-low reset
//   value, dp_in, load      display nibbles / decimal points, latched when load=1
//   lz_en, blink_mask       live leading-zero blanking enable and per-digit blink
//   seg, dp, an             registered segment, decimal point and digit-select pins
//   frame_done              1-clock pulse when the scan wraps back to digit 0
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS   = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int GUARD      = 2,
  parameter int BLINK_DIV  = 64,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  load,
  input  logic                  lz_en,
  input  logic [N_DIGITS-1:0]   blink_mask,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_done
);
  localparam int DW = clog2(SCAN_DIV);
  localparam int IW = clog2(N_DIGITS);
  localparam int BW = clog2(BLINK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic INV = ACTIVE_LOW != 0;
  logic [DW-1:0] div_cnt;
  logic [IW-1:0] idx;
  logic [BW-1:0] blink_cnt;
  logic blink_ph;
  logic [4*N_DIGITS-1:0] sh_val;
  logic [N_DIGITS-1:0] sh_dp, hi_zero, an_sel;
  logic [3:0] nib;
  logic [6:0] glyph;
  logic slot_end, frame_end, guard, blank, acc;
  assign slot_end = div_cnt == DIV_LAST;
  assign frame_end = slot_end && idx == IDX_LAST;
  assign guard = int'(div_cnt) < GUARD;
  assign nib = sh_val[4*idx +: 4];
  assign an_sel = N_DIGITS'(1) << idx;
  assign blank = (lz_en && idx != '0 && hi_zero[idx]) || (blink_mask[idx] && blink_ph);
  // hi_zero[i]: nibbles N_DIGITS-1 down to i are all zero
  always_comb begin
    hi_zero = '0;
    acc = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      acc = acc && (sh_val[4*i +: 4] == 4'd0);
      hi_zero[i] = acc;
    end
  end
  seg7_glyph u_glyph (.nib(nib), .glyph(glyph));
  // Outputs are computed from the current counter/shadow state, so a load on the
  // slot-change edge is already visible when the new slot is first driven.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      idx        <= '0;
      blink_cnt  <= '0;
      blink_ph   <= 1'b0;
      sh_val     <= '0;
      sh_dp      <= '0;
      an         <= {N_DIGITS{INV}};
      seg        <= {7{INV}};
      dp         <= INV;
      frame_done <= 1'b0;
    end else begin
      div_cnt <= slot_end ? '0 : div_cnt + 1'b1;
      if (slot_end) idx <= idx == IDX_LAST ? '0 : idx + 1'b1;
      if (frame_end) blink_cnt <= blink_cnt == BLINK_LAST ? '0 : blink_cnt + 1'b1;
      if (frame_end && blink_cnt == BLINK_LAST) blink_ph <= !blink_ph;
      if (load) begin
        sh_val <= value;
        sh_dp  <= dp_in;
      end
      frame_done <= frame_end;
      an  <= (guard ? '0 : an_sel) ^ {N_DIGITS{INV}};
      seg <= (guard || blank ? SEG7_OFF : glyph) ^ {7{INV}};
      dp  <= (!guard && sh_dp[idx] && !blank) ^ INV;
    end
  end
endmodule
